ddr3_frame_addr_gen: RTL and testbench

//  Parametrised DDR3 address generator for N-buffered, PWM-plane video frames. Sits between the

---
 rtl/ddr3_addr_pkg.sv | 40 ++++
 rtl/ddr3_frame_addr_gen_if.sv | 33 +++
 rtl/ddr3_addr_cnt.sv | 70 +++++++
 rtl/ddr3_frame_addr_gen.sv | 162 ++++++++++++++++
 tb/tb_ddr3_frame_addr_gen.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_addr_pkg.sv
// Shared sizes, buffer index type and error bit positions
// for the DDR3 frame address generator.
package ddr3_addr_pkg;

    typedef logic [1:0] buf_idx_t;

    typedef enum int unsigned {
        ERR_WR_OVF   = 0,
        ERR_RD_EARLY = 1
    } err_bit_e;

    function automatic int unsigned line_sz(
        input int unsigned lb,
        input int unsigned bl
    );
        return lb * bl;
    endfunction

    function automatic int unsigned plane_sz(
        input int unsigned rows,
        input int unsigned lb,
        input int unsigned bl
    );
        return rows * line_sz(lb, bl);
    endfunction

    function automatic int unsigned frame_sz(
        input int unsigned planes,
        input int unsigned rows,
        input int unsigned lb,
        input int unsigned bl
    );
        return planes * plane_sz(rows, lb, bl);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr3_frame_addr_gen_if.sv
// Frame-side, write-port and read-port signals of the
// DDR3 frame address generator.
interface ddr3_frame_addr_gen_if #(
    parameter int unsigned MEM_ADDR_W = 28,
    parameter int unsigned DATA_W     = 256
);
    logic                  vsync;
    logic                  wr_vld_i;
    logic [DATA_W-1:0]     wr_data_i;
    logic                  wr_en_o;
    logic [MEM_ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0]     wr_data_o;
    logic                  rd_req_i;
    logic                  rd_req_o;
    logic [MEM_ADDR_W-1:0] rd_addr_o;
    logic                  rd_wrap_o;
    logic                  tear_o;
    logic [1:0]            addr_err_o;

    modport master (
        output vsync, wr_vld_i, wr_data_i, rd_req_i,
        input  wr_en_o, wr_addr_o, wr_data_o,
        input  rd_req_o, rd_addr_o, rd_wrap_o,
        input  tear_o, addr_err_o
    );

    modport slave (
        input  vsync, wr_vld_i, wr_data_i, rd_req_i,
        output wr_en_o, wr_addr_o, wr_data_o,
        output rd_req_o, rd_addr_o, rd_wrap_o,
        output tear_o, addr_err_o
    );
endinterface

// File: rtl/ddr3_addr_cnt.sv
// Nested burst/row/plane counter; ROW_INNER picks read order
// (rows inside planes) over write order (planes inside rows).
module ddr3_addr_cnt
    import ddr3_addr_pkg::*;
#(
    parameter int unsigned LINE_BURSTS = 4,
    parameter int unsigned ROWS        = 8,
    parameter int unsigned PLANES      = 3,
    parameter bit          ROW_INNER   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         inc,
    output logic [cnt_w(LINE_BURSTS)-1:0] burst,
    output logic [cnt_w(ROWS)-1:0]        row,
    output logic [cnt_w(PLANES)-1:0]      plane,
    output logic                         last
);
    localparam int unsigned MID_N = ROW_INNER ? ROWS : PLANES;
    localparam int unsigned OUT_N = ROW_INNER ? PLANES : ROWS;
    localparam int unsigned BW = cnt_w(LINE_BURSTS);
    localparam int unsigned MW = cnt_w(MID_N);
    localparam int unsigned OW = cnt_w(OUT_N);

    logic [BW-1:0] b_q, b;
    logic [MW-1:0] m_q, m;
    logic [OW-1:0] o_q, o;
    logic b_end, m_end, o_end;

    // clr gives the zero position this cycle so a same-cycle inc counts from it
    assign b = clr ? '0 : b_q;
    assign m = clr ? '0 : m_q;
    assign o = clr ? '0 : o_q;

    assign b_end = (b == BW'(LINE_BURSTS - 1));
    assign m_end = (m == MW'(MID_N - 1));
    assign o_end = (o == OW'(OUT_N - 1));
    assign last  = b_end & m_end & o_end;
    assign burst = b;

    generate
        if (ROW_INNER) begin : g_rd
            assign row   = m;
            assign plane = o;
        end else begin : g_wr
            assign row   = o;
            assign plane = m;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= '0;
            m_q <= '0;
            o_q <= '0;
        end else begin
            b_q <= b;
            m_q <= m;
            o_q <= o;
            if (inc) begin
                b_q <= b_end ? '0 : b + 1'b1;
                if (b_end) begin
                    m_q <= m_end ? '0 : m + 1'b1;
                    if (m_end) o_q <= o_end ? '0 : o + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/ddr3_frame_addr_gen.sv
// DDR3 address generator for N-buffered PWM-plane video frames.
// Define ADDR_RANGE_CHECK_EN for sticky addr_err_o flags.
module ddr3_frame_addr_gen
    import ddr3_addr_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W  = 28,
    parameter int unsigned DATA_W      = 256,
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned LINE_BURSTS = 4,
    parameter int unsigned ROWS        = 2048,
    parameter int unsigned PLANES      = 19,
    parameter int unsigned NUM_BUFS    = 2,
    parameter int unsigned BASE_ADDR   = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    ddr3_frame_addr_gen_if.slave bus
);
    localparam int unsigned LSZ = line_sz(LINE_BURSTS, BURST_LEN);
    localparam int unsigned PSZ = plane_sz(ROWS, LINE_BURSTS, BURST_LEN);
    localparam int unsigned FSZ = frame_sz(PLANES, ROWS, LINE_BURSTS, BURST_LEN);
    localparam int unsigned BW  = cnt_w(LINE_BURSTS);
    localparam int unsigned RW  = cnt_w(ROWS);
    localparam int unsigned PW  = cnt_w(PLANES);

    logic vs_s1, vs_s2, vs_s3, fs;
    buf_idx_t wr_buf, rd_buf, last_done, sel_buf, wr_buf_eff;
    logic done_vld, wr_active, sel_tear;
    logic wr_ok, rd_ok, wr_last, rd_last;
    logic [BW-1:0] wr_burst, rd_burst;
    logic [RW-1:0] wr_row, rd_row;
    logic [PW-1:0] wr_plane, rd_plane;
    logic wr_en_q, rd_req_q, rd_wrap_q, tear_q;
    logic [MEM_ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [1:0] err_q;

    function automatic logic [MEM_ADDR_W-1:0] mk_addr(
        input logic [63:0] b,
        input logic [63:0] p,
        input logic [63:0] r,
        input logic [63:0] k
    );
        return MEM_ADDR_W'(64'(BASE_ADDR) + b * 64'(FSZ) + p * 64'(PSZ)
                           + r * 64'(LSZ) + k * 64'(BURST_LEN));
    endfunction

    assign fs         = vs_s3 & ~vs_s2;
    assign wr_ok      = bus.wr_vld_i & (fs | wr_active);
    assign rd_ok      = bus.rd_req_i & done_vld;
    assign wr_buf_eff = fs ? sel_buf : wr_buf;

    // Avoid the newest frame and the one being read; with no choice, tear
    always_comb begin
        buf_idx_t idx;
        logic hit;
        idx      = '0;
        hit      = 1'b0;
        sel_buf  = wr_buf;
        sel_tear = 1'b0;
        for (int i = 1; i <= int'(NUM_BUFS); i++) begin
            idx = buf_idx_t'((int'(wr_buf) + i) % int'(NUM_BUFS));
            if (!hit && (!done_vld || (idx != last_done && idx != rd_buf))) begin
                sel_buf = idx;
                hit     = 1'b1;
            end
        end
        for (int i = 1; i <= int'(NUM_BUFS); i++) begin
            idx = buf_idx_t'((int'(wr_buf) + i) % int'(NUM_BUFS));
            if (!hit && idx != last_done) begin
                sel_buf  = idx;
                sel_tear = 1'b1;
                hit      = 1'b1;
            end
        end
    end

    ddr3_addr_cnt #(
        .LINE_BURSTS(LINE_BURSTS), .ROWS(ROWS),
        .PLANES(PLANES), .ROW_INNER(1'b0)
    ) u_wr_cnt (
        .clk(clk), .rst_n(rst_n), .clr(fs), .inc(wr_ok),
        .burst(wr_burst), .row(wr_row), .plane(wr_plane), .last(wr_last)
    );

    ddr3_addr_cnt #(
        .LINE_BURSTS(LINE_BURSTS), .ROWS(ROWS),
        .PLANES(PLANES), .ROW_INNER(1'b1)
    ) u_rd_cnt (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(rd_ok),
        .burst(rd_burst), .row(rd_row), .plane(rd_plane), .last(rd_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1     <= 1'b0;
            vs_s2     <= 1'b0;
            vs_s3     <= 1'b0;
            wr_buf    <= buf_idx_t'(NUM_BUFS - 1);
            rd_buf    <= '0;
            last_done <= '0;
            done_vld  <= 1'b0;
            wr_active <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_wrap_q <= 1'b0;
            tear_q    <= 1'b0;
        end else begin
            vs_s1     <= bus.vsync;
            vs_s2     <= vs_s1;
            vs_s3     <= vs_s2;
            wr_en_q   <= wr_ok;
            rd_req_q  <= rd_ok;
            rd_wrap_q <= rd_ok & rd_last;
            tear_q    <= fs & sel_tear;
            if (fs) begin
                wr_buf    <= sel_buf;
                wr_active <= 1'b1;
            end
            if (wr_ok) begin
                wr_addr_q <= mk_addr(64'(wr_buf_eff), 64'(wr_plane),
                                     64'(wr_row), 64'(wr_burst));
                wr_data_q <= bus.wr_data_i;
                if (wr_last) begin
                    wr_active <= 1'b0;
                    last_done <= wr_buf_eff;
                    done_vld  <= 1'b1;
                end
            end
            if (rd_ok) begin
                rd_addr_q <= mk_addr(64'(rd_buf), 64'(rd_plane),
                                     64'(rd_row), 64'(rd_burst));
                if (rd_last) rd_buf <= last_done;
            end
        end
    end

`ifdef ADDR_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            if (bus.wr_vld_i && !wr_ok) err_q[ERR_WR_OVF] <= 1'b1;
            if (bus.rd_req_i && !done_vld) err_q[ERR_RD_EARLY] <= 1'b1;
        end
    end
`else
    assign err_q = '0;
`endif

    assign bus.wr_en_o    = wr_en_q;
    assign bus.wr_addr_o  = wr_addr_q;
    assign bus.wr_data_o  = wr_data_q;
    assign bus.rd_req_o   = rd_req_q;
    assign bus.rd_addr_o  = rd_addr_q;
    assign bus.rd_wrap_o  = rd_wrap_q;
    assign bus.tear_o     = tear_q;
    assign bus.addr_err_o = err_q;
endmodule

// File: tb/tb_ddr3_frame_addr_gen.sv
// Directed bench for ddr3_frame_addr_gen in a small config:
// BL=8 LB=4 ROWS=8 PLANES=3 NUM_BUFS=2 (LINE=32 PLANE=256 FRAME=768).
module tb_ddr3_frame_addr_gen;
    localparam int AW = 28;
    localparam int DW = 256;
    localparam int BL = 8;
    localparam int LB = 4;
    localparam int ROWS = 8;
    localparam int PLANES = 3;
    localparam int LINE = 32;
    localparam int PLANE = 256;
    localparam int FRAME = 768;
    localparam int BEATS = 96;
`ifdef ADDR_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int tear_cnt = 0;

    always #5 clk = ~clk;

    ddr3_frame_addr_gen_if #(.MEM_ADDR_W(AW), .DATA_W(DW)) bus ();

    ddr3_frame_addr_gen #(
        .MEM_ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL),
        .LINE_BURSTS(LB), .ROWS(ROWS), .PLANES(PLANES),
        .NUM_BUFS(2), .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always @(negedge clk) if (bus.tear_o === 1'b1) tear_cnt++;

    // Expected write address of beat n of a frame in buffer b
    function automatic logic [AW-1:0] wr_exp(input int b, input int n);
        int line, k;
        line = n / (LB * PLANES);
        k = n % (LB * PLANES);
        return AW'(b * FRAME + (k / LB) * PLANE + line * LINE + (k % LB) * BL);
    endfunction

    task automatic wr_beat(input int n);
        @(negedge clk);
        bus.wr_vld_i = 1'b1;
        bus.wr_data_i = DW'(32'hC0DE_0000 + n);
        @(posedge clk);
        #1;
        bus.wr_vld_i = 1'b0;
    endtask

    task automatic rd_beat();
        @(negedge clk);
        bus.rd_req_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_req_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.vsync = 1'b1;
        bus.wr_vld_i = 1'b0;
        bus.wr_data_i = '0;
        bus.rd_req_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.wr_en_o, bus.rd_req_o, bus.rd_wrap_o, bus.tear_o, bus.addr_err_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bus.wr_en_o, bus.rd_req_o, bus.rd_wrap_o, bus.tear_o, bus.addr_err_o});
        end
        checks++;
        if ({bus.wr_addr_o, bus.rd_addr_o, bus.wr_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_bus: wr_addr=%0d rd_addr=%0d wr_data=%h want 0",
                     bus.wr_addr_o, bus.rd_addr_o, bus.wr_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fs(input bit exp_tear, input string tag);
        int t0;
        t0 = tear_cnt;
        @(negedge clk);
        bus.vsync = 1'b1;
        repeat (3) @(negedge clk);
        bus.vsync = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (tear_cnt - t0 !== int'(exp_tear)) begin
            errors++;
            $display("FAIL %s tear pulses: got %0d want %0d", tag, tear_cnt - t0, exp_tear);
        end
    endtask

    task automatic test_rd_before_frame();
        for (int j = 0; j < 3; j++) begin
            rd_beat();
            checks++;
            if (bus.rd_req_o !== 1'b0) begin
                errors++;
                $display("FAIL rd_early req %0d: rd_req_o=%b want 0", j, bus.rd_req_o);
            end
        end
        checks++;
        if (bus.addr_err_o !== {CHK, 1'b0}) begin
            errors++;
            $display("FAIL rd_early err: got %b want %b", bus.addr_err_o, {CHK, 1'b0});
        end
    endtask

    task automatic test_first_lines();
        int exp_a[13] = '{0, 8, 16, 24, 256, 264, 272, 280, 512, 520, 528, 536, 32};
        for (int n = 0; n < 13; n++) begin
            wr_beat(n);
            checks++;
            if ({bus.wr_en_o, bus.wr_addr_o} !== {1'b1, AW'(exp_a[n])} ||
                bus.wr_data_o !== DW'(32'hC0DE_0000 + n)) begin
                errors++;
                $display("FAIL first_lines beat %0d: en=%b addr=%0d data=%h want en=1 addr=%0d",
                         n, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o[31:0], exp_a[n]);
            end
        end
    endtask

    task automatic test_write_beats(input int b, input int from, input int to, input string tag);
        logic [AW-1:0] exp;
        for (int n = from; n < to; n++) begin
            wr_beat(n);
            exp = wr_exp(b, n);
            checks++;
            if ({bus.wr_en_o, bus.wr_addr_o} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL %s beat %0d: en=%b addr=%0d want en=1 addr=%0d",
                         tag, n, bus.wr_en_o, bus.wr_addr_o, exp);
            end
        end
    endtask

    task automatic test_overflow_drop();
        wr_beat(999);
        checks++;
        if (bus.wr_en_o !== 1'b0) begin
            errors++;
            $display("FAIL overflow wr_en_o: got %b want 0", bus.wr_en_o);
        end
        checks++;
        if (bus.addr_err_o !== {CHK, CHK}) begin
            errors++;
            $display("FAIL overflow err: got %b want %b", bus.addr_err_o, {CHK, CHK});
        end
    endtask

    task automatic test_read_pass(input int b, input int cnt, input string tag);
        logic [AW-1:0] exp;
        for (int j = 0; j < cnt; j++) begin
            rd_beat();
            exp = AW'(b * FRAME + j * BL);
            checks++;
            if ({bus.rd_req_o, bus.rd_wrap_o, bus.rd_addr_o} !== {1'b1, (j == BEATS - 1), exp}) begin
                errors++;
                $display("FAIL %s beat %0d: req=%b wrap=%b addr=%0d want req=1 wrap=%b addr=%0d",
                         tag, j, bus.rd_req_o, bus.rd_wrap_o, bus.rd_addr_o,
                         (j == BEATS - 1), exp);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        bus.wr_vld_i = 1'b1;
        bus.rd_req_i = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.wr_en_o, bus.rd_req_o, bus.rd_wrap_o, bus.tear_o,
             bus.wr_addr_o, bus.rd_addr_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid async: en=%b req=%b wr_addr=%0d rd_addr=%0d want 0",
                     bus.wr_en_o, bus.rd_req_o, bus.wr_addr_o, bus.rd_addr_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.wr_en_o, bus.rd_req_o, bus.wr_data_o, bus.addr_err_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid edge: en=%b req=%b err=%b want 0",
                     bus.wr_en_o, bus.rd_req_o, bus.addr_err_o);
        end
        @(negedge clk);
        bus.wr_vld_i = 1'b0;
        bus.rd_req_i = 1'b0;
        rst_n = 1'b1;
        rd_beat();
        checks++;
        if (bus.rd_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid rd: rd_req_o=%b want 0", bus.rd_req_o);
        end
    endtask

    initial begin
        test_reset();
        test_rd_before_frame();
        test_fs(1'b0, "fs0");
        test_first_lines();
        test_write_beats(0, 13, BEATS, "frame0");
        test_overflow_drop();
        test_read_pass(0, BEATS, "rd_buf0");
        test_fs(1'b0, "fs1");
        test_write_beats(1, 0, BEATS, "frame1");
        test_read_pass(0, BEATS, "rd_buf0_again");
        test_read_pass(1, BEATS, "rd_buf1");
        test_fs(1'b0, "fs2");
        test_write_beats(0, 0, 40, "partial");
        test_fs(1'b0, "fs_mid");
        test_write_beats(0, 0, 1, "restart");
        test_read_pass(1, BEATS, "rd_keep");
        test_read_pass(1, 1, "rd_after_partial");
        test_write_beats(0, 1, BEATS, "frame2");
        test_fs(1'b1, "fs_tear");
        test_write_beats(1, 0, 1, "tear_buf");
        test_reset_mid_burst();
        test_fs(1'b0, "fs_after_rst");
        test_write_beats(0, 0, 2, "post_rst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
